// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
// Packet-level injection arbiter for one XY-mesh node. Local requesters share the
// router's local input port. One requester is granted at a time in round-robin order.
// The arbiter emits a header flit carrying the destination and length, then forwards
// the payload words. The grant is held until the last payload word is accepted.

module noc_inject_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned X_WIDTH    = 2,
    parameter int unsigned Y_WIDTH    = 2,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [REQ_NUM-1:0]                   req_valid_i,
    output logic [REQ_NUM-1:0]                   req_ready_o,
    input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]   req_data_i,
    input  logic [REQ_NUM-1:0][X_WIDTH-1:0]      req_dest_x_i,
    input  logic [REQ_NUM-1:0][Y_WIDTH-1:0]      req_dest_y_i,
    input  logic [REQ_NUM-1:0][LEN_WIDTH-1:0]    req_len_i,
    output logic [DATA_WIDTH-1:0]                data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [REQ_NUM-1:0]                   grant_o,
    output logic                                 busy_o
);

    localparam int unsigned IDX_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef logic [IDX_WIDTH-1:0] idx_t;
    typedef logic [LEN_WIDTH-1:0] len_t;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload
    } state_e;

    // Architectural state
    state_e               r_state;
    idx_t                 r_rr_ptr;
    idx_t                 r_grant_idx;
    logic [X_WIDTH-1:0]   r_dest_x;
    logic [Y_WIDTH-1:0]   r_dest_y;
    len_t                 r_len;
    len_t                 r_beat_cnt;

    // Combinational helpers
    state_e               w_state_next;
    logic                 w_arb_found;
    idx_t                 w_arb_idx;
    logic                 w_arb_take;
    logic                 w_xfer;
    logic                 w_last_beat;
    idx_t                 w_ptr_inc;
    logic [DATA_WIDTH-1:0] w_header;

    // Round-robin pick: first valid requester scanning upward from r_rr_ptr with wrap.
    always_comb begin
        int unsigned scan;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        scan        = 0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            scan = (32'(r_rr_ptr) + i) % REQ_NUM;
            if (!w_arb_found && req_valid_i[idx_t'(scan)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = idx_t'(scan);
            end
        end
    end

    // Handshake qualifiers and pointer advance past the current owner.
    always_comb begin
        w_arb_take  = (r_state == StIdle) && w_arb_found;
        w_xfer      = (r_state == StPayload) && req_valid_i[r_grant_idx] && ready_i;
        w_last_beat = w_xfer && (r_beat_cnt == r_len);
        if (r_grant_idx == idx_t'(REQ_NUM - 1)) begin
            w_ptr_inc = '0;
        end else begin
            w_ptr_inc = r_grant_idx + idx_t'(1);
        end
    end

    // Header flit assembled from the latched destination and length fields.
    always_comb begin
        w_header = '0;
        w_header[X_WIDTH-1:0]                                   = r_dest_x;
        w_header[X_WIDTH+Y_WIDTH-1:X_WIDTH]                     = r_dest_y;
        w_header[X_WIDTH+Y_WIDTH+LEN_WIDTH-1:X_WIDTH+Y_WIDTH]   = r_len;
        w_header[DATA_WIDTH-1]                                  = 1'b1;
    end

    // Next-state and local-port outputs; payload paths are muxed straight from owner g.
    always_comb begin
        w_state_next = r_state;
        data_o       = '0;
        valid_o      = 1'b0;
        req_ready_o  = '0;
        case (r_state)
            StIdle: begin
                if (w_arb_found) begin
                    w_state_next = StHeader;
                end
            end
            StHeader: begin
                valid_o = 1'b1;
                data_o  = w_header;
                if (ready_i) begin
                    w_state_next = StPayload;
                end
            end
            StPayload: begin
                data_o                   = req_data_i[r_grant_idx];
                valid_o                  = req_valid_i[r_grant_idx];
                req_ready_o[r_grant_idx] = ready_i;
                if (w_last_beat) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Grant and busy are pure decodes of registered state.
    always_comb begin
        grant_o = '0;
        if (r_state != StIdle) begin
            grant_o[r_grant_idx] = 1'b1;
        end
        busy_o = (r_state != StIdle);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Owner capture, beat counting and round-robin pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_arb_take) begin
                r_grant_idx <= w_arb_idx;
                r_dest_x    <= req_dest_x_i[w_arb_idx];
                r_dest_y    <= req_dest_y_i[w_arb_idx];
                r_len       <= req_len_i[w_arb_idx];
                r_beat_cnt  <= '0;
            end
            if (w_xfer) begin
                if (w_last_beat) begin
                    // Counter is not advanced on the final beat so len = all-ones never wraps.
                    r_rr_ptr <= w_ptr_inc;
                end else begin
                    r_beat_cnt <= r_beat_cnt + len_t'(1);
                end
            end
        end
    end

endmodule
